// File: rtl/pattern_gen_pkg.sv
// Shared types and sizing helpers for the serial pattern generator.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/moore_pattern_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeat_n times,
// separated by GAP idle cycles; all outputs are registered Moore decodes of the state.
module moore_pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RW    = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [RW-1:0]    repeat_n,
  output logic             x,
  output logic             frame,
  output logic             done
);

  localparam int unsigned BCW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic             in_ready_q, x_q, frame_q, done_q;
  logic             accept, bit_last, gap_last;

  assign accept   = in_valid && in_ready_q;
  assign bit_last = (bc_q == BCW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
    bc_d    = bc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_d    = pattern;
          rem_d   = (repeat_n == '0) ? RW'(1) : repeat_n;
          bc_d    = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Rotate rather than shift so the pattern is intact for the next repetition.
        sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        bc_d = bc_q + BCW'(1);
        if (bit_last) begin
          rem_d = rem_q - RW'(1);
          bc_d  = '0;
          if (rem_q == RW'(1)) begin
            state_d = ST_DONE;
          end else if (GAP > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      bc_q    <= bc_d;
    end
  end

  // Outputs decode the current state one edge later; in_ready drops on the
  // accepting edge so a single handshake can never be seen twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b1;
      x_q        <= 1'b0;
      frame_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      in_ready_q <= (state_q == ST_IDLE) && !accept;
      x_q        <= (state_q == ST_SEND) && sr_q[WIDTH-1];
      frame_q    <= (state_q == ST_SEND);
      done_q     <= (state_q == ST_DONE);
    end
  end

  generate
    if (GAP > 0) begin : g_gap
      localparam int unsigned GW = cnt_width(GAP);
      logic [GW-1:0] gc_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gc_q <= '0;
        end else if (state_q == ST_GAP) begin
          gc_q <= gc_q + GW'(1);
        end else begin
          gc_q <= '0;
        end
      end

      assign gap_last = (gc_q == GW'(GAP - 1));
    end else begin : g_nogap
      assign gap_last = 1'b1;
    end
  endgenerate

  assign in_ready = in_ready_q;
  assign x        = x_q;
  assign frame    = frame_q;
  assign done     = done_q;

endmodule

// File: tb/tb_moore_pattern_generator.sv
// Scoreboard bench: two generators (GAP=2 and GAP=0) checked cycle by cycle.
module tb_moore_pattern_generator;

  typedef struct packed {
    logic x;
    logic frame;
    logic done;
    logic ready;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       v0, v1;
  logic [3:0] pat0, pat1, rep0, rep1;
  logic       rdy0, x0, f0, d0;
  logic       rdy1, x1, f1, d1;

  int    checks;
  int    errors;
  beat_t exp_q[$];

  moore_pattern_generator #(.WIDTH(4), .RW(4), .GAP(2)) u_gap (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
    .pattern(pat0), .repeat_n(rep0), .x(x0), .frame(f0), .done(d0)
  );

  moore_pattern_generator #(.WIDTH(4), .RW(4), .GAP(0)) u_nogap (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .pattern(pat1), .repeat_n(rep1), .x(x1), .frame(f1), .done(d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    pat0 = '0; pat1 = '0; rep0 = '0; rep1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy0, x0, f0, d0} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_gap: {rdy,x,frame,done}=%b expected 1000", {rdy0, x0, f0, d0});
    end
    checks++;
    if ({rdy1, x1, f1, d1} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_nogap: {rdy,x,frame,done}=%b expected 1000", {rdy1, x1, f1, d1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({rdy0, x0, f0, d0} !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_idle: {rdy,x,frame,done}=%b expected 1000", {rdy0, x0, f0, d0});
    end
  endtask

  // Accept one transaction, then compare every cycle up to in_ready returning.
  task automatic run_txn(input bit nogap, input logic [3:0] pat, input logic [3:0] rep,
                         input string name);
    int unsigned reps, gap;
    int          waited, hits;
    beat_t       e, a;
    logic [3:0]  win;
    reps   = (rep == 0) ? 1 : rep;
    gap    = nogap ? 0 : 2;
    waited = 0;
    @(negedge clk);
    while (!(nogap ? rdy1 : rdy0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 50) begin
      errors++;
      $display("FAIL %s_ready_wait: in_ready=0 after 50 cycles, expected 1", name);
      return;
    end
    if (nogap) begin v1 = 1'b1; pat1 = pat; rep1 = rep; end
    else       begin v0 = 1'b1; pat0 = pat; rep0 = rep; end
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    checks++;
    if ((nogap ? rdy1 : rdy0) !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_drop: in_ready=%b expected 0", name, nogap ? rdy1 : rdy0);
    end
    for (int unsigned r = 0; r < reps; r++) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back('{x: pat[i], frame: 1'b1, done: 1'b0, ready: 1'b0});
      if (r + 1 < reps)
        for (int unsigned g = 0; g < gap; g++) exp_q.push_back('{x: 1'b0, frame: 1'b0, done: 1'b0, ready: 1'b0});
    end
    exp_q.push_back('{x: 1'b0, frame: 1'b0, done: 1'b1, ready: 1'b0});
    exp_q.push_back('{x: 1'b0, frame: 1'b0, done: 1'b0, ready: 1'b1});
    win  = '0;
    hits = 0;
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      a = nogap ? beat_t'({x1, f1, d1, rdy1}) : beat_t'({x0, f0, d0, rdy0});
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s_beat%0d: {x,frame,done,rdy}=%b expected %b", name, n, a, e);
      end
      win = {win[2:0], a.x};
      if (win == pat) hits++;
    end
    checks++;
    if (hits != int'(reps)) begin
      errors++;
      $display("FAIL %s_loopback_hits: %0d detections, expected %0d", name, hits, reps);
    end
  endtask

  task automatic test_single_send();
    run_txn(1'b0, 4'b1011, 4'd1, "single");
  endtask

  task automatic test_repeat_gap();
    run_txn(1'b0, 4'b1101, 4'd2, "repgap");
  endtask

  task automatic test_zero_repeat();
    run_txn(1'b0, 4'b1011, 4'd0, "zerorep");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 4'b1011, 4'd3, "b2b");
  endtask

  task automatic test_reset_mid_send();
    @(negedge clk);
    v0 = 1'b1; pat0 = 4'b1111; rep0 = 4'd2;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({x0, f0} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre: {x,frame}=%b expected 11", {x0, f0});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy0, x0, f0, d0} !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_async: {rdy,x,frame,done}=%b expected 1000", {rdy0, x0, f0, d0});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({rdy0, x0, f0, d0} !== 4'b1000) begin
        errors++;
        $display("FAIL midrst_after%0d: {rdy,x,frame,done}=%b expected 1000", c, {rdy0, x0, f0, d0});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_send();
    test_repeat_gap();
    test_zero_repeat();
    test_back_to_back();
    test_reset_mid_send();
    test_single_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
